adres_pe_multictx: RTL and testbench
====================================

ADRES_PE_MULTICTX -- requirements
Module: adres_pe_multictx

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (>=8).
REQ-002 SHALL have parameter NUM_IN, default 5, number of neighbour data inputs (2..8).
REQ-003 SHALL have parameter NUM_CTX, default 4, number of stored configuration contexts (1..16).
REQ-004 SHALL have parameter RF_DEPTH, default 4, local register-file entries (2..16).
REQ-005 SHALL have port Config_Clock  input  1  sole clock, rising edge.
REQ-006 SHALL have port Config_Reset  input  1  reset; synchronous, active-low.
REQ-007 SHALL have port ConfigIn  input  1  serial configuration data.
REQ-008 SHALL have port ConfigEnable  input  1  shift configuration chain one bit per cycle.
REQ-009 SHALL have port ConfigOut  output  1  serial output, MSB of chain, for daisy-chaining.
REQ-010 SHALL have port run  input  1  execute one context per cycle.
REQ-011 SHALL have port in  input  NUM_IN*WIDTH  packed inputs; input k at bits [k*WIDTH +: WIDTH].
REQ-012 SHALL have port out  output  WIDTH  registered PE result.
REQ-013 SHALL have port out_valid  output  1  out updated by the preceding clock edge.
REQ-014 SHALL have port ctx  output  clog2(NUM_CTX), min 1  index of context executed next.

Function
REQ-015 SHALL hold, per context, a word (LSB to MSB): func[3:0], srcA[SW-1:0], srcB[SW-1:0], byp[SW-1:0], outsel, rf_wr, rf_waddr[RW-1:0], rf_raddr[RW-1:0], const[WIDTH-1:0]; SW=clog2(NUM_IN+2), RW=clog2(RF_DEPTH).
REQ-016 SHALL form one chain of NUM_CTX words (context 0 at LSB); with ConfigEnable=1, chain shifts left one bit per cycle, ConfigIn into bit 0, ConfigOut = chain MSB (combinational from the register).
REQ-017 SHALL ignore run while ConfigEnable=1; ctx forced to 0, out held, out_valid=0, RF held.
REQ-018 SHALL execute the context selected by ctx on each cycle with run=1 and ConfigEnable=0, then advance ctx by 1, wrapping NUM_CTX-1 -> 0.
REQ-019 SHALL hold ctx, out and RF and drive out_valid=0 the cycle after a run=0 cycle.
REQ-020 SHALL select operand A by srcA: 0..NUM_IN-1 = in[k], NUM_IN = const, NUM_IN+1 = rf[rf_raddr]; other codes yield 0.
REQ-021 SHALL select operand B by srcB: 0..NUM_IN-1 = in[k], NUM_IN = const, NUM_IN+1 = out register (feedback); other codes yield 0.
REQ-022 SHALL compute by func: 0 A+B, 1 low WIDTH bits of A*B, 2 A-B, 3 A&B, 4 A|B, 5 A^B, 6 A<<B[s], 7 signed A>>>B[s], 8 A>>B[s], 9 A, 10 (A==B), 11 signed (A<B); 12-15 yield 0; s = clog2(WIDTH) LSBs; add/sub wrap modulo 2^WIDTH.
REQ-023 SHALL load out on an executing cycle with the function result if outsel=0, else in[byp] (byp >= NUM_IN yields 0); latency one cycle.
REQ-024 SHALL write rf[rf_waddr] with the function result on an executing cycle when rf_wr=1; rf_waddr >= RF_DEPTH suppresses the write.
REQ-025 SHALL return the pre-write value when rf_raddr equals rf_waddr in the same executing cycle.
REQ-026 SHALL read rf_raddr >= RF_DEPTH as 0.
REQ-027 SHALL drive out_valid=1 the cycle after each executing cycle, else 0.

Reset
REQ-028 SHALL, on a rising edge with Config_Reset=0, clear the chain, ctx, out, out_valid and all RF entries to 0, overriding ConfigEnable and run, including mid-shift or mid-run.

Configuration
REQ-029 SHALL implement macro ADRES_PE_SAT_EN: defined -> func 0 and 2 saturate as signed (to 2^(WIDTH-1)-1 / -2^(WIDTH-1)); undefined -> they wrap per REQ-022; no other behaviour changes.

Verification
REQ-030 SHALL cover: reset, shift NUM_CTX*CW bits with ctx0 func=0 srcA=0 srcB=NUM_IN, const=7, in0=5, run one cycle -> out=12, out_valid=1 next cycle, ConfigOut reproduces bits shifted in after CW*NUM_CTX delay.
REQ-031 SHALL cover: 4 contexts (add, sub, mul, xor) run 6 cycles -> ctx 0,1,2,3,0,1 and out follows context 0,1,2,3,0,1 results.
REQ-032 SHALL cover: ctx0 rf_wr=1 waddr=1 result 0x10, ctx1 srcA=NUM_IN+1 raddr=1 func=9 -> out=0x10; same-cycle read/write of one entry returns old value.
REQ-033 SHALL cover: A=0x7FFFFFFF, B=1, func=0 -> out=0x80000000 without ADRES_PE_SAT_EN, 0x7FFFFFFF with it.
REQ-034 SHALL cover: Config_Reset=0 during run at ctx=2 -> next cycle ctx=0, out=0, out_valid=0; ConfigEnable=1 mid-run -> ctx=0, out held.
REQ-035 SHALL cover: func=7, A=0x80000000, B=4 -> out=0xF8000000; func=8 -> 0x08000000; func=11 A=-1 B=0 -> out=1.

Source files
------------

// File: rtl/adres_pe_multictx.sv
// ADRES-style processing element with NUM_CTX serially loaded contexts, local RF and feedback.
// Optional macro ADRES_PE_SAT_EN makes add/sub saturate as signed instead of wrapping.
module adres_pe_multictx #(
  parameter int WIDTH    = 32,
  parameter int NUM_IN   = 5,
  parameter int NUM_CTX  = 4,
  parameter int RF_DEPTH = 4
) (
  input  logic                                            Config_Clock,
  input  logic                                            Config_Reset,
  input  logic                                            ConfigIn,
  input  logic                                            ConfigEnable,
  output logic                                            ConfigOut,
  input  logic                                            run,
  input  logic [NUM_IN*WIDTH-1:0]                         in,
  output logic [WIDTH-1:0]                                out,
  output logic                                            out_valid,
  output logic [((NUM_CTX > 1) ? $clog2(NUM_CTX) : 1)-1:0] ctx
);

  localparam int SW   = $clog2(NUM_IN + 2);
  localparam int RW   = $clog2(RF_DEPTH);
  localparam int SH   = $clog2(WIDTH);
  localparam int CTXW = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
  localparam int CW   = 4 + 3 * SW + 2 + 2 * RW + WIDTH;
  localparam int TOT  = NUM_CTX * CW;

  localparam int O_SRCA   = 4;
  localparam int O_SRCB   = O_SRCA + SW;
  localparam int O_BYP    = O_SRCB + SW;
  localparam int O_OUTSEL = O_BYP + SW;
  localparam int O_RFWR   = O_OUTSEL + 1;
  localparam int O_WADDR  = O_RFWR + 1;
  localparam int O_RADDR  = O_WADDR + RW;
  localparam int O_CONST  = O_RADDR + RW;

`ifdef ADRES_PE_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  logic [TOT-1:0]   chain;
  logic [CW-1:0]    word;
  logic [WIDTH-1:0] rf [RF_DEPTH];

  logic [3:0]       func;
  logic [SW-1:0]    srca, srcb, byp;
  logic             outsel, rf_wr;
  logic [RW-1:0]    waddr, raddr;
  logic [WIDTH-1:0] cst;

  logic [WIDTH-1:0] rd_data, op_a, op_b, byp_data, sum, diff, res;
  logic [SH-1:0]    shamt;
  logic             exec;

  // Context word currently addressed by ctx; chain is the only config storage.
  assign word   = chain[int'(ctx) * CW +: CW];
  assign func   = word[3:0];
  assign srca   = word[O_SRCA +: SW];
  assign srcb   = word[O_SRCB +: SW];
  assign byp    = word[O_BYP +: SW];
  assign outsel = word[O_OUTSEL];
  assign rf_wr  = word[O_RFWR];
  assign waddr  = word[O_WADDR +: RW];
  assign raddr  = word[O_RADDR +: RW];
  assign cst    = word[O_CONST +: WIDTH];

  assign ConfigOut = chain[TOT-1];
  assign exec      = run & ~ConfigEnable;
  assign shamt     = op_b[SH-1:0];

  always_comb begin
    rd_data = '0;
    if (int'(raddr) < RF_DEPTH) rd_data = rf[raddr];

    op_a = '0;
    if (int'(srca) < NUM_IN)          op_a = in[int'(srca) * WIDTH +: WIDTH];
    else if (int'(srca) == NUM_IN)     op_a = cst;
    else if (int'(srca) == NUM_IN + 1) op_a = rd_data;

    op_b = '0;
    if (int'(srcb) < NUM_IN)          op_b = in[int'(srcb) * WIDTH +: WIDTH];
    else if (int'(srcb) == NUM_IN)     op_b = cst;
    else if (int'(srcb) == NUM_IN + 1) op_b = out;

    byp_data = '0;
    if (int'(byp) < NUM_IN) byp_data = in[int'(byp) * WIDTH +: WIDTH];
  end

  always_comb begin
    sum  = op_a + op_b;
    diff = op_a - op_b;
`ifdef ADRES_PE_SAT_EN
    // Signed overflow clamps toward the sign of operand A.
    if (op_a[WIDTH-1] == op_b[WIDTH-1] && sum[WIDTH-1] != op_a[WIDTH-1])
      sum = op_a[WIDTH-1] ? SMIN : SMAX;
    if (op_a[WIDTH-1] != op_b[WIDTH-1] && diff[WIDTH-1] != op_a[WIDTH-1])
      diff = op_a[WIDTH-1] ? SMIN : SMAX;
`endif
    res = '0;
    case (func)
      4'd0:    res = sum;
      4'd1:    res = op_a * op_b;
      4'd2:    res = diff;
      4'd3:    res = op_a & op_b;
      4'd4:    res = op_a | op_b;
      4'd5:    res = op_a ^ op_b;
      4'd6:    res = op_a << shamt;
      4'd7:    res = $signed(op_a) >>> shamt;
      4'd8:    res = op_a >> shamt;
      4'd9:    res = op_a;
      4'd10:   res = {{(WIDTH-1){1'b0}}, (op_a == op_b)};
      4'd11:   res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: res = '0;
    endcase
  end

  always_ff @(posedge Config_Clock) begin
    if (!Config_Reset) begin
      chain     <= '0;
      ctx       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
    end else begin
      out_valid <= exec;
      if (ConfigEnable) begin
        chain <= {chain[TOT-2:0], ConfigIn};
        ctx   <= '0;
      end else if (run) begin
        ctx <= (ctx == CTXW'(NUM_CTX - 1)) ? '0 : ctx + 1'b1;
        out <= outsel ? byp_data : res;
        // RF read above sees the pre-write value of the same entry.
        if (rf_wr && int'(waddr) < RF_DEPTH) rf[waddr] <= res;
      end
    end
  end

endmodule

// File: tb/tb_adres_pe_multictx.sv
// Bench for adres_pe_multictx: directed scenarios with literal expectations plus
// randomized programs checked every cycle against a bit-queue/arithmetic model.
module tb_adres_pe_multictx;

  localparam int WIDTH    = 32;
  localparam int NUM_IN   = 5;
  localparam int NUM_CTX  = 4;
  localparam int RF_DEPTH = 4;
  localparam int SW       = $clog2(NUM_IN + 2);
  localparam int RW       = $clog2(RF_DEPTH);
  localparam int CW       = 4 + 3 * SW + 2 + 2 * RW + WIDTH;
  localparam int TOT      = NUM_CTX * CW;

  logic                    clk;
  logic                    rst_n;
  logic                    cfg_in;
  logic                    cfg_en;
  logic                    cfg_out;
  logic                    run;
  logic [NUM_IN*WIDTH-1:0] din;
  logic [WIDTH-1:0]        out;
  logic                    out_valid;
  logic [1:0]              ctx;

  int errors = 0;
  int checks = 0;
  bit checking = 0;

  adres_pe_multictx #(
    .WIDTH(WIDTH), .NUM_IN(NUM_IN), .NUM_CTX(NUM_CTX), .RF_DEPTH(RF_DEPTH)
  ) dut (
    .Config_Clock(clk),
    .Config_Reset(rst_n),
    .ConfigIn(cfg_in),
    .ConfigEnable(cfg_en),
    .ConfigOut(cfg_out),
    .run(run),
    .in(din),
    .out(out),
    .out_valid(out_valid),
    .ctx(ctx)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_hist[i] is the bit shifted in i shifts ago, i.e. chain bit i.
  bit          m_hist[$];
  int          m_ctx;
  logic [31:0] m_out;
  bit          m_valid;
  logic [31:0] m_rf [RF_DEPTH];

  function automatic logic [31:0] fld(int c, int off, int w);
    logic [31:0] v = '0;
    for (int i = 0; i < w; i++) v[i] = m_hist[c * CW + off + i];
    return v;
  endfunction

  function automatic logic [31:0] get_in(int k);
    return din[k * WIDTH +: WIDTH];
  endfunction

  task automatic model_step();
    int f, sa, sb, bp, osel, wr, wa, ra, sh;
    logic [31:0] a, b, r, cst;
    logic [63:0] p;
    longint s;
    if (!rst_n) begin
      m_hist.delete();
      for (int i = 0; i < TOT; i++) m_hist.push_back(1'b0);
      m_ctx = 0; m_out = '0; m_valid = 0;
      for (int i = 0; i < RF_DEPTH; i++) m_rf[i] = '0;
    end else if (cfg_en) begin
      m_hist.push_front(cfg_in);
      void'(m_hist.pop_back());
      m_ctx = 0; m_valid = 0;
    end else if (run) begin
      f    = fld(m_ctx, 0, 4);
      sa   = fld(m_ctx, 4, SW);
      sb   = fld(m_ctx, 4 + SW, SW);
      bp   = fld(m_ctx, 4 + 2 * SW, SW);
      osel = fld(m_ctx, 4 + 3 * SW, 1);
      wr   = fld(m_ctx, 5 + 3 * SW, 1);
      wa   = fld(m_ctx, 6 + 3 * SW, RW);
      ra   = fld(m_ctx, 6 + 3 * SW + RW, RW);
      cst  = fld(m_ctx, 6 + 3 * SW + 2 * RW, WIDTH);
      if (sa < NUM_IN) a = get_in(sa);
      else if (sa == NUM_IN) a = cst;
      else if (sa == NUM_IN + 1) a = (ra < RF_DEPTH) ? m_rf[ra] : 32'd0;
      else a = 32'd0;
      if (sb < NUM_IN) b = get_in(sb);
      else if (sb == NUM_IN) b = cst;
      else if (sb == NUM_IN + 1) b = m_out;
      else b = 32'd0;
      sh = int'(b % WIDTH);
      r = 32'd0;
      case (f)
        0, 2: begin
          s = (f == 0) ? longint'(signed'(a)) + longint'(signed'(b))
                       : longint'(signed'(a)) - longint'(signed'(b));
`ifdef ADRES_PE_SAT_EN
          if (s > 64'sd2147483647) s = 64'sd2147483647;
          if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
          r = s[31:0];
        end
        1: begin p = longint'(a) * longint'(b); r = p[31:0]; end
        3: r = a & b;
        4: r = a | b;
        5: r = a ^ b;
        6: r = a << sh;
        7: r = signed'(a) >>> sh;
        8: r = a >> sh;
        9: r = a;
        10: r = (a == b) ? 32'd1 : 32'd0;
        11: r = (signed'(a) < signed'(b)) ? 32'd1 : 32'd0;
        default: r = 32'd0;
      endcase
      m_out = osel ? ((bp < NUM_IN) ? get_in(bp) : 32'd0) : r;
      if (wr && wa < RF_DEPTH) m_rf[wa] = r;
      m_ctx = (m_ctx + 1) % NUM_CTX;
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
  endtask

  always @(posedge clk) model_step();

  // One compare process, mid-cycle, against the model.
  always @(negedge clk) begin
    if (checking) begin
      check("model_out", out, m_out);
      check("model_out_valid", 32'(out_valid), 32'(m_valid));
      check("model_ctx", 32'(ctx), 32'(m_ctx));
      check("model_cfg_out", 32'(cfg_out), 32'(m_hist[TOT-1]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cfg_en = 1'b0; run = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic set_in(input int k, input logic [31:0] v);
    din[k * WIDTH +: WIDTH] = v;
  endtask

  function automatic logic [CW-1:0] mkw(int func, int sa, int sb, int bp, int osel, int wr,
                                        int wa, int ra, logic [31:0] cst);
    return {cst, RW'(ra), RW'(wa), 1'(wr), 1'(osel), SW'(bp), SW'(sb), SW'(sa), 4'(func)};
  endfunction

  // Shifts p in MSB first so the chain equals p afterwards; optionally checks
  // that ConfigOut replays the previous chain contents TOT shifts late.
  task automatic load_prog(input logic [TOT-1:0] p, input bit chk_prev, input logic [TOT-1:0] prev);
    run = 1'b0;
    for (int j = 0; j < TOT; j++) begin
      if (chk_prev) check("cfg_out_replay", 32'(cfg_out), 32'(prev[TOT-1-j]));
      cfg_en = 1'b1;
      cfg_in = p[TOT-1-j];
      tick();
    end
    cfg_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [TOT-1:0] prog1, prog2, prog3, prog4, rprog;
  logic [31:0] exp_q[$];
  logic [31:0] held;

  initial begin
    rst_n = 1'b0; cfg_in = 1'b0; cfg_en = 1'b0; run = 1'b0; din = '0;
    do_reset();
    checking = 1;

    // Reset state.
    check("rst_ctx", 32'(ctx), 32'd0);
    check("rst_out", out, 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_cfg_out", 32'(cfg_out), 32'd0);

    // Basic load and single execute: 5 + 7.
    prog1 = '0;
    prog1[0 +: CW] = mkw(0, 0, NUM_IN, 0, 0, 0, 0, 0, 32'd7);
    for (int c = 1; c < NUM_CTX; c++) prog1[c * CW +: CW] = mkw(9, NUM_IN, 0, 0, 0, 0, 0, 0, 32'(c + 100));
    load_prog(prog1, 1, '0);
    set_in(0, 32'd5);
    run = 1'b1; tick(); run = 1'b0;
    check("basic_out", out, 32'd12);
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_ctx", 32'(ctx), 32'd1);
    tick();
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_out_held", out, 32'd12);
    check("idle_ctx_held", 32'(ctx), 32'd1);

    // Four contexts add/sub/mul/xor cycling.
    prog2 = '0;
    prog2[0 * CW +: CW] = mkw(0, 0, 1, 0, 0, 0, 0, 0, 32'd0);
    prog2[1 * CW +: CW] = mkw(2, 0, 1, 0, 0, 0, 0, 0, 32'd0);
    prog2[2 * CW +: CW] = mkw(1, 0, 1, 0, 0, 0, 0, 0, 32'd0);
    prog2[3 * CW +: CW] = mkw(5, 0, 1, 0, 0, 0, 0, 0, 32'd0);
    load_prog(prog2, 1, prog1);
    set_in(0, 32'd100); set_in(1, 32'd7);
    exp_q = '{32'd107, 32'd93, 32'd700, 32'd99};
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("cyc_ctx", 32'(ctx), 32'(i % 4));
      tick();
      check("cyc_out", out, exp_q[i % 4]);
      check("cyc_valid", 32'(out_valid), 32'd1);
    end
    run = 1'b0; tick();

    // RF write then read, and same-cycle read-before-write.
    prog3 = '0;
    prog3[0 * CW +: CW] = mkw(0, NUM_IN, 7, 0, 0, 1, 1, 0, 32'h10);
    prog3[1 * CW +: CW] = mkw(9, NUM_IN + 1, 0, 0, 0, 0, 0, 1, 32'd0);
    prog3[2 * CW +: CW] = mkw(0, NUM_IN + 1, NUM_IN, 0, 0, 1, 1, 1, 32'd5);
    prog3[3 * CW +: CW] = mkw(9, NUM_IN + 1, 0, 0, 0, 0, 0, 1, 32'd0);
    load_prog(prog3, 1, prog2);
    exp_q = '{32'h10, 32'h10, 32'h15, 32'h15};
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rf_out", out, exp_q[i]);
    end
    run = 1'b0; tick();

    // Overflow, arithmetic/logical shift right, signed less-than.
    prog4 = '0;
    prog4[0 * CW +: CW] = mkw(0, 0, NUM_IN, 0, 0, 0, 0, 0, 32'd1);
    prog4[1 * CW +: CW] = mkw(7, 1, NUM_IN, 0, 0, 0, 0, 0, 32'd4);
    prog4[2 * CW +: CW] = mkw(8, 1, NUM_IN, 0, 0, 0, 0, 0, 32'd4);
    prog4[3 * CW +: CW] = mkw(11, 2, NUM_IN, 0, 0, 0, 0, 0, 32'd0);
    load_prog(prog4, 1, prog3);
    set_in(0, 32'h7FFF_FFFF); set_in(1, 32'h8000_0000); set_in(2, 32'hFFFF_FFFF);
`ifdef ADRES_PE_SAT_EN
    exp_q = '{32'h7FFF_FFFF, 32'hF800_0000, 32'h0800_0000, 32'd1};
`else
    exp_q = '{32'h8000_0000, 32'hF800_0000, 32'h0800_0000, 32'd1};
`endif
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("edge_out", out, exp_q[i]);
    end
    run = 1'b0; tick();

    // Reset mid-run at ctx 2, then ConfigEnable mid-run.
    load_prog(prog2, 1, prog4);
    set_in(0, 32'd100); set_in(1, 32'd7);
    run = 1'b1; tick(); tick();
    check("pre_rst_ctx", 32'(ctx), 32'd2);
    rst_n = 1'b0; tick(); rst_n = 1'b1; run = 1'b0;
    check("midrst_ctx", 32'(ctx), 32'd0);
    check("midrst_out", out, 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_cfg_out", 32'(cfg_out), 32'd0);
    load_prog(prog2, 1, '0);
    run = 1'b1; tick(); tick(); tick();
    held = 32'd700;
    check("pre_cfg_out", out, held);
    cfg_en = 1'b1; cfg_in = 1'b0; tick();
    check("cfgen_ctx", 32'(ctx), 32'd0);
    check("cfgen_out_held", out, held);
    check("cfgen_valid", 32'(out_valid), 32'd0);
    cfg_en = 1'b0; run = 1'b0; tick();

    // Randomized programs and control, checked each cycle by the model.
    for (int blk = 0; blk < 5; blk++) begin
      for (int c = 0; c < NUM_CTX; c++)
        rprog[c * CW +: CW] = mkw($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
                                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                                  $urandom_range(0, 3), $urandom_range(0, 3),
                                  ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom);
      load_prog(rprog, 0, '0);
      for (int cyc = 0; cyc < 300; cyc++) begin
        for (int k = 0; k < NUM_IN; k++)
          set_in(k, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
        run    = ($urandom_range(0, 3) != 0);
        cfg_en = ($urandom_range(0, 40) == 0);
        cfg_in = 1'($urandom_range(0, 1));
        rst_n  = ($urandom_range(0, 150) != 0);
        tick();
      end
      rst_n = 1'b1; cfg_en = 1'b0; run = 1'b0;
      tick();
    end

    tick();
    checking = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
